// File: rtl/spio_uart_fifo_fc.sv
// Cyclic-buffer FIFO for serial-port words with occupancy count, hysteretic
// high-water flag for RTS/CTS, synchronous flush and optional drop-on-full.
module spio_uart_fifo_fc #(
    parameter int unsigned BUFFER_ADDR_BITS = 4,
    parameter int unsigned WORD_SIZE        = 8,
    parameter int unsigned DROP_ON_FULL     = 0,
    parameter int unsigned OVF_BITS         = 8
) (
    input  logic                        CLK_IN,
    input  logic                        RESET_IN,
    input  logic                        FLUSH_IN,
    input  logic [BUFFER_ADDR_BITS:0]   HIGH_WATER_IN,
    input  logic [BUFFER_ADDR_BITS:0]   LOW_WATER_IN,
    output logic                        HIGH_OUT,
    output logic [BUFFER_ADDR_BITS:0]   OCCUPANCY_OUT,
    output logic [OVF_BITS-1:0]         OVERFLOW_COUNT_OUT,
    input  logic [WORD_SIZE-1:0]        IN_DATA_IN,
    input  logic                        IN_VLD_IN,
    output logic                        IN_RDY_OUT,
    output logic [WORD_SIZE-1:0]        OUT_DATA_OUT,
    output logic                        OUT_VLD_OUT,
    input  logic                        OUT_RDY_IN
);

    localparam int unsigned DEPTH = 1 << BUFFER_ADDR_BITS;
    localparam logic [BUFFER_ADDR_BITS:0] PTR_ONE = 1;
    localparam logic [OVF_BITS-1:0] OVF_ONE = 1;

    logic [BUFFER_ADDR_BITS:0] head;
    logic [BUFFER_ADDR_BITS:0] tail;
    logic [WORD_SIZE-1:0]      buffer [DEPTH];
    logic [OVF_BITS-1:0]       ovf_count;
    logic                      high;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    // MSB of each pointer is a wrap bit so every slot is usable.
    assign empty = (head == tail);
    assign full  = (head[BUFFER_ADDR_BITS-1:0] == tail[BUFFER_ADDR_BITS-1:0]) &&
                   (head[BUFFER_ADDR_BITS] != tail[BUFFER_ADDR_BITS]);
    assign pop   = !empty && OUT_RDY_IN;

    generate
        if (DROP_ON_FULL != 0) begin : g_drop
            assign IN_RDY_OUT = 1'b1;
            assign push       = IN_VLD_IN && (!full || pop);
            assign drop       = IN_VLD_IN && full && !pop;
        end else begin : g_backpressure
            // Ready depends only on state, never on OUT_RDY_IN.
            assign IN_RDY_OUT = !full;
            assign push       = IN_VLD_IN && !full;
            assign drop       = 1'b0;
        end
    endgenerate

    assign OCCUPANCY_OUT      = head - tail;
    assign OUT_VLD_OUT        = !empty;
    assign OUT_DATA_OUT       = empty ? '0 : buffer[tail[BUFFER_ADDR_BITS-1:0]];
    assign OVERFLOW_COUNT_OUT = ovf_count;
    assign HIGH_OUT           = high;

    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            head      <= '0;
            tail      <= '0;
            ovf_count <= '0;
            high      <= 1'b0;
        end else if (FLUSH_IN) begin
            head      <= '0;
            tail      <= '0;
            ovf_count <= '0;
            high      <= 1'b0;
        end else begin
            if (push) head <= head + PTR_ONE;
            if (pop)  tail <= tail + PTR_ONE;
            if (drop && (ovf_count != '1)) ovf_count <= ovf_count + OVF_ONE;
            // Set wins over clear when the thresholds overlap.
            if (OCCUPANCY_OUT >= HIGH_WATER_IN) begin
                high <= 1'b1;
            end else if (OCCUPANCY_OUT <= LOW_WATER_IN) begin
                high <= 1'b0;
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK_IN) begin
        if (push && !FLUSH_IN) begin
            buffer[head[BUFFER_ADDR_BITS-1:0]] <= IN_DATA_IN;
        end
    end

endmodule

// File: tb/tb_spio_uart_fifo_fc.sv
// Scoreboard bench: one stimulus stream drives a back-pressure and a drop-mode
// instance (depth 4); a queue model predicts each one independently.
module tb_spio_uart_fifo_fc;

    localparam int DEPTH = 4;
    localparam int OVF_MAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [2:0] hw = 3'd3;
    logic [2:0] lw = 3'd1;
    logic [7:0] in_data = 8'h00;
    logic       in_vld = 1'b0;
    logic       out_rdy = 1'b0;

    logic       high_o     [2];
    logic [2:0] occ_o      [2];
    logic [7:0] ovf_o      [2];
    logic       in_rdy_o   [2];
    logic [7:0] out_data_o [2];
    logic       out_vld_o  [2];

    int checks = 0;
    int passes = 0;

    int         m_occ  [2];
    int         m_ovf  [2];
    bit         m_high [2];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic [2:0] nhw = 3'd3;
    logic [2:0] nlw = 3'd1;

    always #5 clk = ~clk;

    spio_uart_fifo_fc #(
        .BUFFER_ADDR_BITS(2), .WORD_SIZE(8), .DROP_ON_FULL(0), .OVF_BITS(8)
    ) u_bp (
        .CLK_IN(clk), .RESET_IN(rst), .FLUSH_IN(flush),
        .HIGH_WATER_IN(hw), .LOW_WATER_IN(lw), .HIGH_OUT(high_o[0]),
        .OCCUPANCY_OUT(occ_o[0]), .OVERFLOW_COUNT_OUT(ovf_o[0]),
        .IN_DATA_IN(in_data), .IN_VLD_IN(in_vld), .IN_RDY_OUT(in_rdy_o[0]),
        .OUT_DATA_OUT(out_data_o[0]), .OUT_VLD_OUT(out_vld_o[0]), .OUT_RDY_IN(out_rdy)
    );

    spio_uart_fifo_fc #(
        .BUFFER_ADDR_BITS(2), .WORD_SIZE(8), .DROP_ON_FULL(1), .OVF_BITS(8)
    ) u_drop (
        .CLK_IN(clk), .RESET_IN(rst), .FLUSH_IN(flush),
        .HIGH_WATER_IN(hw), .LOW_WATER_IN(lw), .HIGH_OUT(high_o[1]),
        .OCCUPANCY_OUT(occ_o[1]), .OVERFLOW_COUNT_OUT(ovf_o[1]),
        .IN_DATA_IN(in_data), .IN_VLD_IN(in_vld), .IN_RDY_OUT(in_rdy_o[1]),
        .OUT_DATA_OUT(out_data_o[1]), .OUT_VLD_OUT(out_vld_o[1]), .OUT_RDY_IN(out_rdy)
    );

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", name, d, act, exp, $time);
    endtask

    task automatic sb_clear(input int d);
        if (d == 0) sb0.delete();
        else sb1.delete();
    endtask

    task automatic sb_push(input int d, input logic [7:0] v);
        if (d == 0) sb0.push_back(v);
        else sb1.push_back(v);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_occ[d]  = 0;
            m_ovf[d]  = 0;
            m_high[d] = 1'b0;
            sb_clear(d);
        end
    endtask

    // Predict the effect of the coming clock edge from the inputs just driven.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit full_m, pop_m, push_m, drop_m;
            if (flush) begin
                m_occ[d]  = 0;
                m_ovf[d]  = 0;
                m_high[d] = 1'b0;
                sb_clear(d);
            end else begin
                if (m_occ[d] >= int'(hw)) m_high[d] = 1'b1;
                else if (m_occ[d] <= int'(lw)) m_high[d] = 1'b0;
                full_m = (m_occ[d] == DEPTH);
                pop_m  = (m_occ[d] > 0) && out_rdy;
                if (d == 0) begin
                    push_m = in_vld && !full_m;
                    drop_m = 1'b0;
                end else begin
                    push_m = in_vld && (!full_m || pop_m);
                    drop_m = in_vld && full_m && !pop_m;
                end
                if (drop_m && m_ovf[d] < OVF_MAX) m_ovf[d]++;
                if (push_m) sb_push(d, in_data);
                m_occ[d] = m_occ[d] + int'(push_m) - int'(pop_m);
            end
        end
    endtask

    task automatic check_state();
        for (int d = 0; d < 2; d++) begin
            chk("occupancy", d, int'(occ_o[d]), m_occ[d]);
            chk("out_vld", d, int'(out_vld_o[d]), int'(m_occ[d] != 0));
            chk("in_rdy", d, int'(in_rdy_o[d]), (d == 1) ? 1 : int'(m_occ[d] != DEPTH));
            chk("high", d, int'(high_o[d]), int'(m_high[d]));
            chk("overflow", d, int'(ovf_o[d]), m_ovf[d]);
            if (m_occ[d] == 0) chk("empty_data", d, int'(out_data_o[d]), 0);
        end
    endtask

    task automatic check_reset_values();
        for (int d = 0; d < 2; d++) begin
            chk("rst_occ", d, int'(occ_o[d]), 0);
            chk("rst_vld", d, int'(out_vld_o[d]), 0);
            chk("rst_data", d, int'(out_data_o[d]), 0);
            chk("rst_in_rdy", d, int'(in_rdy_o[d]), 1);
            chk("rst_high", d, int'(high_o[d]), 0);
            chk("rst_ovf", d, int'(ovf_o[d]), 0);
        end
    endtask

    task automatic step(input bit f, input bit v, input logic [7:0] data, input bit r);
        @(negedge clk);
        check_state();
        flush   = f;
        in_vld  = v;
        in_data = data;
        out_rdy = r;
        hw      = nhw;
        lw      = nlw;
        model_step();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: compare the presented word with the scoreboard head, pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && !flush) begin
                for (int d = 0; d < 2; d++) begin
                    if (out_vld_o[d]) begin
                        int n;
                        logic [7:0] front;
                        n = (d == 0) ? sb0.size() : sb1.size();
                        chk("sb_nonempty", d, int'(n > 0), 1);
                        if (n > 0) begin
                            front = (d == 0) ? sb0[0] : sb1[0];
                            chk("out_data", d, int'(out_data_o[d]), int'(front));
                            if (out_rdy) begin
                                if (d == 0) void'(sb0.pop_front());
                                else void'(sb1.pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] fill_words [4];
        fill_words[0] = 8'h11; fill_words[1] = 8'h22;
        fill_words[2] = 8'h33; fill_words[3] = 8'h44;
        model_reset();
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        model_step();

        // Fill, offer a fifth word, then drain.
        nhw = 3'd5; nlw = 3'd0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, fill_words[i], 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Wrap: ten words one at a time.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
            step(1'b0, 1'b0, 8'h00, 1'b1);
        end

        // Full with simultaneous push and pop.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h66, 1'b1);
        idle();
        step(1'b1, 1'b0, 8'h00, 1'b0);

        // Drop mode saturation, then flush.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1);
        idle();

        // Hysteresis HIGH=3, LOW=1.
        nhw = 3'd3; nlw = 3'd1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        idle();
        idle();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'h00, 1'b1);
            idle();
            idle();
        end

        // Valid pulsed while full, then withdrawn.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
        step(1'b0, 1'b1, 8'h99, 1'b0);
        idle();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomised traffic with occasional flush and threshold changes.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                nhw = 3'($urandom_range(0, 7));
                nlw = 3'($urandom_range(0, 7));
            end
            step($urandom_range(0, 99) < 2, $urandom_range(0, 2) != 0, 8'($urandom),
                 $urandom_range(0, 2) == 0);
        end

        // Reset mid-stream: outputs must clear before any clock edge.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        @(negedge clk);
        check_state();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        flush   = 1'b0;
        nhw = 3'd3; nlw = 3'd1;
        hw = nhw; lw = nlw;
        #1;
        rst = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        model_step();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hD0 + i), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        check_state();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spio_uart_fifo_fc.md
Name: spio_uart_fifo_fc

Overview:
- Parametrised successor to the UART receive FIFO: a cyclic-buffer FIFO for serial-port bytes using all 2^BUFFER_ADDR_BITS slots.
- Adds a full-width occupancy count, a hysteretic high-water flag to drive RTS/CTS flow control, a synchronous flush, and an optional drop-on-full mode with a saturating overflow counter.
- Sits between the UART receiver/transmitter and the spI/O rdy/vld fabric.

Parameters:
- BUFFER_ADDR_BITS, 4, log2 of depth; depth DEPTH = 1<<BUFFER_ADDR_BITS; all slots usable.
- WORD_SIZE, 8, bits per stored word.
- DROP_ON_FULL, 0, 0 = back-pressure when full; 1 = IN_RDY_OUT tied high, words offered while full are discarded and counted.
- OVF_BITS, 8, width of the saturating overflow counter.

Ports:
- CLK_IN  in  1  common clock, rising edge.
- RESET_IN  in  1  asynchronous active-high reset.
- FLUSH_IN  in  1  synchronous flush: empties the FIFO and clears the overflow counter.
- HIGH_WATER_IN  in  BUFFER_ADDR_BITS+1  occupancy at or above which HIGH_OUT asserts.
- LOW_WATER_IN  in  BUFFER_ADDR_BITS+1  occupancy at or below which HIGH_OUT deasserts.
- HIGH_OUT  out  1  registered flow-control flag.
- OCCUPANCY_OUT  out  BUFFER_ADDR_BITS+1  words held, 0..DEPTH.
- OVERFLOW_COUNT_OUT  out  OVF_BITS  dropped words, saturating.
- IN_DATA_IN  in  WORD_SIZE  input word.
- IN_VLD_IN  in  1  input valid.
- IN_RDY_OUT  out  1  input ready.
- OUT_DATA_OUT  out  WORD_SIZE  oldest word.
- OUT_VLD_OUT  out  1  output valid.
- OUT_RDY_IN  in  1  output ready.

Behaviour:
- Pointers:
  - head and tail are BUFFER_ADDR_BITS+1 bits wide; the MSB is a wrap bit.
  - empty = (head == tail).
  - full = low bits equal and MSBs differ.
  - OCCUPANCY_OUT = head - tail, modulo 2^(BUFFER_ADDR_BITS+1), combinational.
- Output side:
  - OUT_VLD_OUT = !empty.
  - OUT_DATA_OUT = buffer[tail low bits] when !empty, else all-zero (never X).
  - Pop occurs when OUT_VLD_OUT && OUT_RDY_IN.
- Input side, DROP_ON_FULL=0:
  - IN_RDY_OUT = !full.
  - Push when IN_RDY_OUT && IN_VLD_IN.
  - A pop in the same cycle does not make a full FIFO accept (no comb path from OUT_RDY_IN to IN_RDY_OUT).
- Input side, DROP_ON_FULL=1:
  - IN_RDY_OUT = 1.
  - Push when IN_VLD_IN && (!full || pop).
  - IN_VLD_IN && full && !pop drops the word and increments the overflow counter.
  - The counter saturates at all-ones.
- IN_VLD_IN may fall before acceptance; nothing is written in that case. Correctness never depends on vld being held.
- Push writes buffer[head low bits] and head += 1; pop does tail += 1. Simultaneous push and pop leaves occupancy unchanged.
- Flush:
  - FLUSH_IN high at an edge sets head = tail = 0 and clears the overflow counter.
  - Flush overrides any push, pop or drop in the same cycle; those are ignored and not counted.
  - The outputs show empty from the following cycle.
- HIGH_OUT (register):
  - Evaluated at each edge from the pre-edge occupancy.
  - Set if occupancy >= HIGH_WATER_IN.
  - Else cleared if occupancy <= LOW_WATER_IN.
  - Else holds.
  - Flush clears it.
  - Lags OCCUPANCY_OUT by one cycle.
  - If LOW_WATER_IN >= HIGH_WATER_IN, the set condition has priority.
- Reset (asynchronous, immediate):
  - head = tail = 0 and overflow count = 0.
  - HIGH_OUT = 0, OUT_VLD_OUT = 0, OUT_DATA_OUT = 0.
  - IN_RDY_OUT = 1, OCCUPANCY_OUT = 0.
  - Buffer contents are not reset.
  - Reset mid-transfer discards all words.
- Latency: a pushed word is visible on OUT_DATA_OUT/OUT_VLD_OUT in the cycle after acceptance; no bypass.

Test Plan:
- Fill/drain (ADDR_BITS=2, DROP=0):
  - Push 0x11,0x22,0x33,0x44 -> OCCUPANCY 4, IN_RDY 0.
  - Fifth word 0x55 held with vld is not accepted.
  - Drain -> 0x11..0x44 in order, then OUT_VLD 0.
- Wrap:
  - Push/pop 10 words one at a time -> each output equals its input.
  - OCCUPANCY alternates between 1 and 0 and never reaches 2.
- Full with simultaneous push+pop:
  - DROP=0: occupancy stays 3 after the pop, the word is not accepted.
  - DROP=1: word accepted, occupancy stays 4, count 0.
- Drop mode:
  - With the FIFO full, 300 offered words and no pops -> OVERFLOW_COUNT 255 (OVF_BITS=8).
  - Flush -> count 0, OUT_VLD 0 next cycle.
- Hysteresis (HIGH=3, LOW=1):
  - Push 3 -> HIGH_OUT 1 one cycle after occupancy reaches 3.
  - Pop to 2 -> stays 1.
  - Pop to 1 -> 0 next cycle.
- Vld withdrawal and reset:
  - Pulse IN_VLD while full, then drop it -> no write.
  - Assert RESET_IN mid-stream -> outputs go to reset values immediately, before any clock edge.
